// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: frame-aligned 1-to-4 TDM demultiplexer.
// Serial words arrive as ch0, ch1, ch2, ch3, ... with a sync flag on ch0.
// Words are staged per slot and the whole frame is published together on
// the edge that captures the ch3 word.
module tdm_demux_1to4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_sync,
   input  logic             err_clr,
   output logic [WIDTH-1:0] ch0_out,
   output logic [WIDTH-1:0] ch1_out,
   output logic [WIDTH-1:0] ch2_out,
   output logic [WIDTH-1:0] ch3_out,
   output logic             frame_vld,
   output logic             locked,
   output logic [1:0]       slot,
   output logic             sync_err
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             take_word;
   logic             take_sync;
   logic             publish;
   logic             err_set;
   logic [1:0]       slot_nxt;
   logic [WIDTH-1:0] stage0;
   logic [WIDTH-1:0] stage1;
   logic [WIDTH-1:0] stage2;

   assign locked = (state == LOCKED);

   // Lock state register; only reset can leave LOCKED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= UNLOCKED;
      end else begin
         state <= state_nxt;
      end
   end

   // Decide whether this word is accepted, where it goes, and whether it
   // completes a frame or breaks one.
   always_comb begin
      state_nxt = state;
      take_word = 1'b0;
      take_sync = 1'b0;
      publish   = 1'b0;
      err_set   = 1'b0;
      slot_nxt  = slot;
      if (in_valid) begin
         if (in_sync) begin
            // A sync always restarts the frame at ch0; arriving anywhere
            // other than slot 0 means the previous frame was cut short.
            take_word = 1'b1;
            take_sync = 1'b1;
            state_nxt = LOCKED;
            slot_nxt  = 2'd1;
            err_set   = (slot != 2'd0);
         end else if (state == LOCKED) begin
            // Unsynced words while locked follow the slot counter, including
            // a ch0 word whose sync flag went missing.
            take_word = 1'b1;
            slot_nxt  = slot + 2'd1;
            publish   = (slot == 2'd3);
         end
      end
   end

   // Slot counter, staging registers, published outputs and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot      <= 2'd0;
         stage0    <= '0;
         stage1    <= '0;
         stage2    <= '0;
         ch0_out   <= '0;
         ch1_out   <= '0;
         ch2_out   <= '0;
         ch3_out   <= '0;
         frame_vld <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         frame_vld <= publish;
         if (take_word) begin
            slot <= slot_nxt;
            if (take_sync) begin
               stage0 <= in_data;
            end else begin
               case (slot)
                  2'd0:    stage0 <= in_data;
                  2'd1:    stage1 <= in_data;
                  2'd2:    stage2 <= in_data;
                  default: ;
               endcase
            end
         end
         // The ch3 word bypasses staging so the frame appears one clock
         // after its last word.
         if (publish) begin
            ch0_out <= stage0;
            ch1_out <= stage1;
            ch2_out <= stage2;
            ch3_out <= in_data;
         end
         if (err_set) begin
            sync_err <= 1'b1;
         end else if (err_clr) begin
            sync_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: directed bench for the 1-to-4 TDM demultiplexer.
module tb_tdm_demux_1to4;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_sync;
   logic             err_clr;
   logic [WIDTH-1:0] ch0_out;
   logic [WIDTH-1:0] ch1_out;
   logic [WIDTH-1:0] ch2_out;
   logic [WIDTH-1:0] ch3_out;
   logic             frame_vld;
   logic             locked;
   logic [1:0]       slot;
   logic             sync_err;

   int tests  = 0;
   int failed = 0;

   tdm_demux_1to4 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_sync   (in_sync),
      .err_clr   (err_clr),
      .ch0_out   (ch0_out),
      .ch1_out   (ch1_out),
      .ch2_out   (ch2_out),
      .ch3_out   (ch3_out),
      .frame_vld (frame_vld),
      .locked    (locked),
      .slot      (slot),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
      chk({tag, "_ch0"}, 32'(ch0_out), 32'(e0));
      chk({tag, "_ch1"}, 32'(ch1_out), 32'(e1));
      chk({tag, "_ch2"}, 32'(ch2_out), 32'(e2));
      chk({tag, "_ch3"}, 32'(ch3_out), 32'(e3));
   endtask

   // Present one word for one clock; outputs are sampled 1 time unit after the edge.
   task automatic send(input logic [7:0] d, input logic s);
      in_data  = d;
      in_sync  = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_data = 8'hEE;
         in_sync = 1'b1;
         @(posedge clk);
         #1;
      end
      in_sync = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_data  = '0;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      err_clr  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_frame("rst", 8'h00, 8'h00, 8'h00, 8'h00);
      chk("rst_vld", 32'(frame_vld), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_slot", 32'(slot), 32'd0);
      chk("rst_err", 32'(sync_err), 32'd0);
      rst = 1'b0;

      // Scenario 1: back-to-back frame
      send(8'hA1, 1'b1);
      chk("s1_slot1", 32'(slot), 32'd1);
      chk("s1_locked_early", 32'(locked), 32'd1);
      send(8'hB2, 1'b0);
      send(8'hC3, 1'b0);
      chk("s1_vld_pre", 32'(frame_vld), 32'd0);
      chk_frame("s1_hold_pre", 8'h00, 8'h00, 8'h00, 8'h00);
      send(8'hD4, 1'b0);
      chk_frame("s1", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      chk("s1_vld", 32'(frame_vld), 32'd1);
      chk("s1_slot", 32'(slot), 32'd0);
      chk("s1_locked", 32'(locked), 32'd1);
      idle(1);
      chk("s1_vld_drop", 32'(frame_vld), 32'd0);
      chk_frame("s1_hold", 8'hA1, 8'hB2, 8'hC3, 8'hD4);

      // Missing-sync ch0 word while locked: frame still assembles, no error
      send(8'hE5, 1'b0);
      send(8'hF6, 1'b0);
      send(8'h07, 1'b0);
      send(8'h08, 1'b0);
      chk_frame("nosync", 8'hE5, 8'hF6, 8'h07, 8'h08);
      chk("nosync_vld", 32'(frame_vld), 32'd1);
      chk("nosync_err", 32'(sync_err), 32'd0);

      // Scenario 2: unlocked words are dropped
      do_reset();
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      chk("s2_slot_unl", 32'(slot), 32'd0);
      chk("s2_locked_unl", 32'(locked), 32'd0);
      send(8'h33, 1'b1);
      send(8'h44, 1'b0);
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      chk_frame("s2", 8'h33, 8'h44, 8'h55, 8'h66);
      chk("s2_vld", 32'(frame_vld), 32'd1);
      chk("s2_err", 32'(sync_err), 32'd0);

      // Scenario 3: mid-frame sync aborts partial frame
      send(8'h01, 1'b1);
      send(8'h02, 1'b0);
      chk("s3_slot2", 32'(slot), 32'd2);
      send(8'h0A, 1'b1);
      chk("s3_err_set", 32'(sync_err), 32'd1);
      chk("s3_slot_restart", 32'(slot), 32'd1);
      chk("s3_no_pub", 32'(frame_vld), 32'd0);
      send(8'h0B, 1'b0);
      send(8'h0C, 1'b0);
      chk_frame("s3_hold", 8'h33, 8'h44, 8'h55, 8'h66);
      send(8'h0D, 1'b0);
      chk_frame("s3", 8'h0A, 8'h0B, 8'h0C, 8'h0D);
      chk("s3_vld", 32'(frame_vld), 32'd1);
      idle(2);
      chk("s3_err_sticky", 32'(sync_err), 32'd1);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk("s3_err_clr", 32'(sync_err), 32'd0);

      // Scenario 4: gaps between words (idle cycles carry junk sync/data)
      do_reset();
      send(8'hA1, 1'b1);
      send(8'hB2, 1'b0);
      idle(1);
      send(8'hC3, 1'b0);
      idle(2);
      chk("s4_slot3", 32'(slot), 32'd3);
      chk("s4_vld_pre", 32'(frame_vld), 32'd0);
      send(8'hD4, 1'b0);
      chk_frame("s4", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      chk("s4_vld", 32'(frame_vld), 32'd1);
      idle(3);
      chk("s4_vld_once", 32'(frame_vld), 32'd0);
      chk("s4_err", 32'(sync_err), 32'd0);

      // Scenario 5: asynchronous reset mid-frame
      send(8'h5A, 1'b1);
      send(8'h5B, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_frame("s5_async", 8'h00, 8'h00, 8'h00, 8'h00);
      chk("s5_slot", 32'(slot), 32'd0);
      chk("s5_locked", 32'(locked), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(8'h61, 1'b1);
      send(8'h62, 1'b0);
      send(8'h63, 1'b0);
      send(8'h64, 1'b0);
      chk_frame("s5", 8'h61, 8'h62, 8'h63, 8'h64);
      chk("s5_vld", 32'(frame_vld), 32'd1);

      // Scenario 6: set wins over simultaneous clear
      send(8'h71, 1'b1);
      send(8'h72, 1'b0);
      err_clr = 1'b1;
      send(8'h73, 1'b1);
      chk("s6_set_wins", 32'(sync_err), 32'd1);
      err_clr = 1'b0;
      idle(1);
      chk("s6_stays", 32'(sync_err), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
